rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 46 ++++
 rtl/rst_filt.sv | 73 +++++++
 rtl/rst_seq.sv | 120 ++++++++++++
 tb/tb_rst_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared constants for the core reset sequencer: counter widths, FSM state
// encodings, reset-cause codes and the source-priority helper.
package rst_seq_pkg;

    localparam int CNT_W = 24;
    localparam int DB_W  = 16;

    // Level both synchronizers hold while res is applied: "reset asserted".
    localparam logic SYNC_ASSERTED = 1'b0;

    typedef enum logic [1:0] {
        S_HOLD   = 2'b00,
        S_RUN    = 2'b01,
        S_REBOOT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR    = 2'b00,
        CAUSE_BTN    = 2'b01,
        CAUSE_LOCK   = 2'b10,
        CAUSE_REBOOT = 2'b11
    } cause_e;

    typedef struct packed {
        logic btn;        // button pressed (filtered)
        logic lock_lost;  // PLL not locked (synchronized)
        logic reboot;     // software reboot request
    } src_t;

    // Sources that hold the core in S_HOLD; reboot only matters from S_RUN.
    function automatic logic hold_active(input src_t s);
        return s.btn | s.lock_lost;
    endfunction

    // Cause recorded when leaving S_RUN: button > lock loss > reboot.
    function automatic cause_e run_exit_cause(input src_t s);
        if (s.btn) begin
            return CAUSE_BTN;
        end else if (s.lock_lost) begin
            return CAUSE_LOCK;
        end else begin
            return CAUSE_REBOOT;
        end
    endfunction

endpackage

// File: rtl/rst_filt.sv
// Two-flop synchronizer for one asynchronous reset source, with an optional
// stability filter compiled in by RST_DEBOUNCE_EN and enabled per instance.
module rst_filt
    import rst_seq_pkg::*;
#(
    parameter logic [DB_W-1:0] DB_CYCLES = 16'd1024,
    parameter logic            DEBOUNCE  = 1'b1
) (
    input  logic clk_cog,
    input  logic res,
    input  logic async_i,
    output logic level_o
);

    logic sync1_q;
    logic sync2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            sync1_q <= SYNC_ASSERTED;
            sync2_q <= SYNC_ASSERTED;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
        end
    end

    if (DEBOUNCE) begin : g_db
`ifdef RST_DEBOUNCE_EN
        localparam logic [DB_W-1:0] DB_LAST = DB_CYCLES - 1'b1;

        logic            db_q;
        logic            db_d;
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;

        // A new level is adopted on its DB_CYCLES-th consecutive sample;
        // any return to the accepted level restarts the run from zero.
        // NOTE: defaults at the top of always_comb keep every path assigned,
        // which is what prevents latch inference.
        always_comb begin
            db_d     = db_q;
            db_cnt_d = '0;
            if (sync2_q != db_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_cog) begin
            if (res) begin
                db_q     <= SYNC_ASSERTED;
                db_cnt_q <= '0;
            end else begin
                db_q     <= db_d;
                db_cnt_q <= db_cnt_d;
            end
        end

        assign level_o = db_q;
`else
        assign level_o = sync2_q;
`endif
    end else begin : g_bypass
        assign level_o = sync2_q;
    end

endmodule

// File: rtl/rst_seq.sv
// Core reset sequencer: holds nres low until button, PLL lock and reboot
// sources have been quiet for HOLD_CYCLES. Optional RST_DEBOUNCE_EN filters
// the button input.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] HOLD_CYCLES = 24'd1_600_000,
    parameter logic [DB_W-1:0]  DB_CYCLES   = 16'd1024
) (
    input  logic       clk_cog,
    input  logic       res,
    input  logic       inp_resn,
    input  logic       pll_lock,
    input  logic       reboot,
    output logic       nres,
    output logic       reset_to,
    output logic [1:0] rst_cause
);

    // HOLD_CYCLES must be at least 1; zero would make the terminal count wrap.
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_CYCLES - 1'b1;

    logic btn_n;
    logic lock_ok;
    src_t src;

    rst_filt #(
        .DB_CYCLES (DB_CYCLES),
        .DEBOUNCE  (1'b1)
    ) u_filt_btn (
        .clk_cog (clk_cog),
        .res     (res),
        .async_i (inp_resn),
        .level_o (btn_n)
    );

    // Lock loss must act immediately, so this path never debounces.
    rst_filt #(
        .DB_CYCLES (DB_CYCLES),
        .DEBOUNCE  (1'b0)
    ) u_filt_lock (
        .clk_cog (clk_cog),
        .res     (res),
        .async_i (pll_lock),
        .level_o (lock_ok)
    );

    always_comb begin
        src.btn       = ~btn_n;
        src.lock_lost = ~lock_ok;
        src.reboot    = reboot;
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             nres_q;
    logic             reset_to_q;
    cause_e           cause_q;

    always_ff @(posedge clk_cog) begin
        if (res) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            nres_q     <= 1'b0;
            reset_to_q <= 1'b0;
            cause_q    <= CAUSE_POR;
        end else begin
            reset_to_q <= 1'b0;
            case (state_q)
                S_HOLD: begin
                    // Sources restart the count but never rewrite the cause.
                    if (hold_active(src)) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q    <= S_RUN;
                        nres_q     <= 1'b1;
                        reset_to_q <= 1'b1;
                    end else if (cnt_q < HOLD_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_RUN: begin
                    if (hold_active(src)) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        nres_q  <= 1'b0;
                        cause_q <= run_exit_cause(src);
                    end else if (src.reboot) begin
                        state_q <= S_REBOOT;
                        nres_q  <= 1'b0;
                        cause_q <= run_exit_cause(src);
                    end
                end

                S_REBOOT: begin
                    if (src.btn) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        cause_q <= CAUSE_BTN;
                    end else if (!src.reboot) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                    end
                end

                default: begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                    nres_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nres      = nres_q;
    assign reset_to  = reset_to_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with HOLD_CYCLES=16 and DB_CYCLES=8, plus a
// HOLD_CYCLES=1 instance sharing the same inputs.
module tb_rst_seq;

    logic       clk;
    logic       res;
    logic       inp_resn;
    logic       pll_lock;
    logic       reboot;
    logic       nres;
    logic       reset_to;
    logic [1:0] rst_cause;
    logic       nres_h1;
    logic       reset_to_h1;
    logic [1:0] rst_cause_h1;

    int checks = 0;
    int errors = 0;

    rst_seq #(.HOLD_CYCLES(24'd16), .DB_CYCLES(16'd8)) dut (
        .clk_cog   (clk),
        .res       (res),
        .inp_resn  (inp_resn),
        .pll_lock  (pll_lock),
        .reboot    (reboot),
        .nres      (nres),
        .reset_to  (reset_to),
        .rst_cause (rst_cause)
    );

    rst_seq #(.HOLD_CYCLES(24'd1), .DB_CYCLES(16'd8)) dut_h1 (
        .clk_cog   (clk),
        .res       (res),
        .inp_resn  (inp_resn),
        .pll_lock  (pll_lock),
        .reboot    (reboot),
        .nres      (nres_h1),
        .reset_to  (reset_to_h1),
        .rst_cause (rst_cause_h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       res;
        logic       btn_n;
        logic       lock;
        logic       rb;
        int         n;
        logic       e_nres;
        logic       e_rto;
        logic [1:0] e_cause;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic l, input logic rb, input int n,
                       input logic en, input logic er, input logic [1:0] ec);
        vec_t v;
        v.res = r; v.btn_n = b; v.lock = l; v.rb = rb; v.n = n;
        v.e_nres = en; v.e_rto = er; v.e_cause = ec;
        vecs.push_back(v);
    endtask

    // Steps are counted in negedges from the negedge where stimulus changed;
    // a reset_to of -1 means no pulse arrived within the budget.
    task automatic wait_release(input int budget, output int t_main, output int t_h1);
        t_main = -1;
        t_h1   = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (reset_to && t_main < 0) t_main = i;
            if (reset_to_h1 && t_h1 < 0) t_h1 = i;
            if (t_main >= 0 && t_h1 >= 0) break;
        end
    endtask

    initial begin
        int t_main;
        int t_h1;
        int lows;
        int pulses;

        res      = 1'b1;
        inp_resn = 1'b1;
        pll_lock = 1'b1;
        reboot   = 1'b0;

`ifndef RST_DEBOUNCE_EN
        //  res btn lock rb  n   nres rto cause
        add(1, 1, 1, 0,  2, 0, 0, 2'b00); // reset state
        add(0, 1, 1, 0, 17, 0, 0, 2'b00); // power-on: release is 16+2 after res
        add(0, 1, 1, 0,  1, 1, 1, 2'b00);
        add(0, 1, 1, 0,  1, 1, 0, 2'b00); // single-cycle pulse
        add(0, 1, 1, 0,  5, 1, 0, 2'b00);
        add(0, 0, 1, 0,  2, 1, 0, 2'b00); // button press, still in sync pipe
        add(0, 0, 1, 0,  1, 0, 0, 2'b01); // nres drops on the 3rd cycle
        add(0, 0, 1, 0,  2, 0, 0, 2'b01);
        add(0, 1, 1, 0, 17, 0, 0, 2'b01); // release: 18 cycles to nres
        add(0, 1, 1, 0,  1, 1, 1, 2'b01);
        add(0, 1, 1, 0,  1, 1, 0, 2'b01);
        add(0, 1, 1, 1,  1, 0, 0, 2'b11); // reboot acts in one cycle
        add(0, 1, 1, 1,  9, 0, 0, 2'b11);
        add(0, 1, 1, 0, 16, 0, 0, 2'b11); // 16 cycles after reboot=0 sampled
        add(0, 1, 1, 0,  1, 1, 1, 2'b11);
        add(0, 0, 0, 0,  3, 0, 0, 2'b01); // button + lock loss together
        add(0, 1, 1, 0, 17, 0, 0, 2'b01);
        add(0, 1, 1, 0,  1, 1, 1, 2'b01);
        add(0, 1, 0, 0,  3, 0, 0, 2'b10); // lock loss alone
        add(0, 1, 1, 0, 12, 0, 0, 2'b10); // count reaches 10
        add(0, 1, 0, 0,  8, 0, 0, 2'b10); // lock drops mid-count
        add(0, 1, 1, 0, 17, 0, 0, 2'b10); // recount from lock return
        add(0, 1, 1, 0,  1, 1, 1, 2'b10);
        add(0, 1, 1, 1,  2, 0, 0, 2'b11);
        add(0, 1, 1, 0,  5, 0, 0, 2'b11); // in S_HOLD, counting
        add(0, 0, 1, 0,  4, 0, 0, 2'b11); // press in S_HOLD keeps cause
        add(0, 1, 1, 0, 17, 0, 0, 2'b11);
        add(0, 1, 1, 0,  1, 1, 1, 2'b11);
        add(0, 1, 1, 1,  4, 0, 0, 2'b11); // S_REBOOT
        add(0, 0, 1, 1,  3, 0, 0, 2'b01); // button overrides reboot cause
        add(0, 1, 1, 0, 17, 0, 0, 2'b01);
        add(0, 1, 1, 0,  1, 1, 1, 2'b01);
        add(0, 1, 0, 0,  2, 1, 0, 2'b01); // lock loss still in sync pipe
        add(0, 1, 0, 1,  1, 0, 0, 2'b10); // lock loss beats reboot
        add(0, 1, 1, 0, 17, 0, 0, 2'b10);
        add(0, 1, 1, 0,  1, 1, 1, 2'b10);
        add(1, 1, 1, 0,  1, 0, 0, 2'b00); // res in S_RUN
        add(0, 1, 1, 0, 17, 0, 0, 2'b00);
        add(0, 1, 1, 0,  1, 1, 1, 2'b00);
        add(0, 0, 1, 0,  3, 0, 0, 2'b01);
        add(0, 1, 1, 0, 10, 0, 0, 2'b01); // mid-count
        add(1, 1, 1, 0,  1, 0, 0, 2'b00); // res mid-count
        add(0, 1, 1, 0, 17, 0, 0, 2'b00);
        add(0, 1, 1, 0,  1, 1, 1, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            res      = vecs[i].res;
            inp_resn = vecs[i].btn_n;
            pll_lock = vecs[i].lock;
            reboot   = vecs[i].rb;
            repeat (vecs[i].n) @(negedge clk);
            check($sformatf("vec%0d.nres", i), {1'b0, nres}, {1'b0, vecs[i].e_nres});
            check($sformatf("vec%0d.reset_to", i), {1'b0, reset_to}, {1'b0, vecs[i].e_rto});
            check($sformatf("vec%0d.rst_cause", i), rst_cause, vecs[i].e_cause);
        end

        // HOLD_CYCLES=1 releases on the first quiet cycle after the sync delay.
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        wait_release(40, t_main, t_h1);
        check_int("por_release_cycle", t_main, 18);
        check_int("h1_release_cycle", t_h1, 3);

        // Saturated counter in S_RUN must never produce another pulse.
        pulses = 0;
        lows   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (reset_to) pulses++;
            if (!nres) lows++;
        end
        check_int("run_extra_pulses", pulses, 0);
        check_int("run_nres_lows", lows, 0);
`else
        @(negedge clk);
        check("db.reset_nres", {1'b0, nres}, 2'b00);
        check("db.reset_rto", {1'b0, reset_to}, 2'b00);
        check("db.reset_cause", rst_cause, 2'b00);

        // The filter starts at "pressed" and needs 8 stable cycles first.
        res = 1'b0;
        wait_release(60, t_main, t_h1);
        check_int("db.por_release_cycle", t_main, 26);
        check_int("db.h1_release_cycle", t_h1, 11);

        // Lock loss bypasses the filter: plain 2-cycle sync latency.
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        check("db.lock_pipe_nres", {1'b0, nres}, 2'b01);
        @(negedge clk);
        check("db.lock_nres", {1'b0, nres}, 2'b00);
        check("db.lock_cause", rst_cause, 2'b10);
        pll_lock = 1'b1;
        wait_release(40, t_main, t_h1);
        check_int("db.lock_release_cycle", t_main, 18);
        check_int("db.h1_lock_release_cycle", t_h1, 3);

        inp_resn = 1'b0;
        repeat (3) @(negedge clk);
        inp_resn = 1'b1;
        lows = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!nres) lows++;
        end
        check_int("db.glitch_nres_lows", lows, 0);
        check("db.glitch_cause", rst_cause, 2'b10);

        inp_resn = 1'b0;
        repeat (10) @(negedge clk);
        check("db.press_pending_nres", {1'b0, nres}, 2'b01);
        @(negedge clk);
        check("db.press_nres", {1'b0, nres}, 2'b00);
        check("db.press_cause", rst_cause, 2'b01);
        repeat (9) @(negedge clk);
        inp_resn = 1'b1;
        pulses = 0;
        repeat (3) @(negedge clk);
        check("db.press_hold_nres", {1'b0, nres}, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
